position_hit_unit: RTL and testbench
====================================

Name: position_hit_unit

Overview:
- Sits between the two per-player FSMs and the renderer.
- Consumes both players' current state codes and maintains both players' horizontal positions.
- Generates the per-player hitscan pulses that the FSMs consume.
- One clk cycle is one game frame, the same timebase as the player FSMs. P1 always faces right and P2 always faces left.

Parameters:
- SCREEN_W, 640, playfield width in px.
- BODY_W, 32, player body width in px; x is the body's left edge.
- STEP, 3, px moved per frame in FORWARD/BACKWARD.
- BASIC_REACH, 40, max body gap in px for a basic attack to connect.
- DIR_REACH, 56, max body gap in px for a directional attack to connect.
- P1_START, 160, P1 x after reset.
- P2_START, 448, P2 x after reset.

Ports:
- clk  in  1  frame clock.
- reset_n  in  1  asynchronous reset, active-low.
- freeze  in  1  game over / pause; holds positions and suppresses hits.
- p1_state  in  4  P1 FSM current state code.
- p2_state  in  4  P2 FSM current state code.
- p1_x  out  10  P1 left edge, registered.
- p2_x  out  10  P2 left edge, registered.
- hitscan_p1  out  1  one-cycle pulse: P1 is struck.
- hitscan_p2  out  1  one-cycle pulse: P2 is struck.
- gap  out  10  p2_x - p1_x - BODY_W, registered, for debug/HUD.

Behaviour:
- State codes: 0 IDLE, 1 FORWARD, 2 BACKWARD, 4 BASIC_ACTIVE, 7 DIR_ACTIVE, 9 HIT_STUN, 10 BLOCK_STUN. All other codes mean no movement and no hit.
- Reset (async, reset_n=0): p1_x=P1_START, p2_x=P2_START, gap=P2_START-P1_START-BODY_W, both hitscans 0, both hit latches clear. Reset mid-attack discards the latch.
- Invariant: 0 <= p1_x, p1_x+BODY_W <= p2_x, p2_x+BODY_W <= SCREEN_W. Never violated.
- Movement arithmetic is 11-bit signed internally, then clamped. Each frame, when freeze=0:
  - P1 FORWARD: +STEP, clamped to the gap. P1 BACKWARD: -STEP, clamped at 0.
  - P2 FORWARD: -STEP, clamped to the gap. P2 BACKWARD: +STEP, clamped at SCREEN_W-BODY_W.
- Both forward with gap < 2*STEP: P1 takes floor(gap/2), P2 takes the remainder; gap becomes 0.
- One forward, the other backward: the backward move is applied first, then the forward move is clamped against the new position.
- Hit test uses registered positions and the current gap.
  - P1 strikes P2 if p1_state==4 and gap<=BASIC_REACH, or p1_state==7 and gap<=DIR_REACH. P2 strikes P1 symmetrically.
  - Result is registered: hitscan asserts the cycle after the qualifying frame.
- One hit per active window:
  - An attacker's latch is set on the first qualifying frame.
  - Further pulses are blocked while the latch is set.
  - The latch clears when the attacker leaves 4/7.
  - A 4->7 transition without leaving active keeps the latch.
- Defender in 9 or 10 when a hit qualifies: no pulse, but the latch is still set (the attack is consumed).
- Mutual hits in the same frame: both pulses assert in the same cycle (trade).
- freeze=1: positions hold, hitscans are 0, latches hold. On release, the hit test resumes next frame.

Optional Feature:
- Macro: STUN_PUSHBACK_EN.
- Defined: a player in state 9 or 10 moves backward 1 px per frame, wall-clamped; movement priority matches BACKWARD.
- Undefined: stunned players do not move.

Test Plan:
- Reset, hold both IDLE 10 cycles -> p1_x=160, p2_x=448, gap=256, no hitscan.
- P1 FORWARD 100 cycles, P2 IDLE -> p1_x=416, gap=0, held at 416 thereafter.
- Positions p1_x=300, p2_x=336 (gap 4), both FORWARD -> p1_x=302, p2_x=334, gap=0 next cycle.
- Gap 40, P1 state 4 for 2 cycles -> hitscan_p2 single pulse one cycle after the first active frame. Repeat at gap 41 -> no pulse. State 7 at gap 56 -> pulse.
- Both in state 4 at gap 10 in the same cycle -> hitscan_p1 and hitscan_p2 pulse together. Defender in state 9 -> no pulse, latch set; a second active window re-arms.
- Assert reset_n low mid-attack with the latch set; release, then attack again in range -> pulse issued.

Source files
------------

// File: rtl/position_hit_unit_if.sv
// position_hit_unit_if: FSM state inputs, freeze, and position/hitscan outputs of position_hit_unit.
interface position_hit_unit_if;
    logic       freeze;
    logic [3:0] p1_state;
    logic [3:0] p2_state;
    logic [9:0] p1_x;
    logic [9:0] p2_x;
    logic [9:0] gap;
    logic       hitscan_p1;
    logic       hitscan_p2;
    modport master (output freeze, p1_state, p2_state, input p1_x, p2_x, gap, hitscan_p1, hitscan_p2);
    modport slave  (input freeze, p1_state, p2_state, output p1_x, p2_x, gap, hitscan_p1, hitscan_p2);
endinterface

// File: rtl/position_hit_unit.sv
// position_hit_unit: per-frame player movement with clamping and one-hit-per-window hitscan pulses.
// Define STUN_PUSHBACK_EN to make stunned players drift backward 1 px per frame.
module position_hit_unit #(
    parameter int SCREEN_W    = 640,
    parameter int BODY_W      = 32,
    parameter int STEP        = 3,
    parameter int BASIC_REACH = 40,
    parameter int DIR_REACH   = 56,
    parameter int P1_START    = 160,
    parameter int P2_START    = 448
) (
    input logic                clk,
    input logic                reset_n,
    position_hit_unit_if.slave bus
);
    localparam logic [3:0] ST_FWD   = 4'd1;
    localparam logic [3:0] ST_BWD   = 4'd2;
    localparam logic [3:0] ST_BASIC = 4'd4;
    localparam logic [3:0] ST_DIR   = 4'd7;
    localparam logic [3:0] ST_HSTUN = 4'd9;
    localparam logic [3:0] ST_BSTUN = 4'd10;
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] STEP2_S = 11'(2 * STEP);
    localparam logic signed [10:0] BODY_S  = 11'(BODY_W);
    localparam logic signed [10:0] XMAX_S  = 11'(SCREEN_W - BODY_W);
    localparam logic [9:0] BR = 10'(BASIC_REACH);
    localparam logic [9:0] DR = 10'(DIR_REACH);

    logic [9:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d, gap_q, gap_d;
    logic hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
    logic lat1_q, lat1_d, lat2_q, lat2_d;
    logic signed [10:0] x1, x2, b1, b2, m1, m2, n1, n2, ng, h, a1, a2;
    logic f1, f2, both, stun1, stun2, q1, q2, act1, act2;

    always_comb begin
        stun1 = bus.p1_state == ST_HSTUN || bus.p1_state == ST_BSTUN;
        stun2 = bus.p2_state == ST_HSTUN || bus.p2_state == ST_BSTUN;
        f1 = bus.p1_state == ST_FWD;
        f2 = bus.p2_state == ST_FWD;
`ifdef STUN_PUSHBACK_EN
        b1 = (bus.p1_state == ST_BWD) ? STEP_S : stun1 ? 11'sd1 : 11'sd0;
        b2 = (bus.p2_state == ST_BWD) ? STEP_S : stun2 ? 11'sd1 : 11'sd0;
`else
        b1 = (bus.p1_state == ST_BWD) ? STEP_S : 11'sd0;
        b2 = (bus.p2_state == ST_BWD) ? STEP_S : 11'sd0;
`endif
        x1 = signed'({1'b0, p1_x_q});
        x2 = signed'({1'b0, p2_x_q});
        // Backward moves resolve against the walls first; forward moves then share what gap remains.
        m1 = x1 - b1;
        m2 = x2 + b2;
        n1 = m1[10] ? 11'sd0 : m1;
        n2 = (m2 > XMAX_S) ? XMAX_S : m2;
        ng = n2 - n1 - BODY_S;
        both = f1 && f2 && ng < STEP2_S;
        h = ng >>> 1;
        a1 = both ? h : f1 ? ((ng < STEP_S) ? ng : STEP_S) : 11'sd0;
        a2 = both ? ng - h : f2 ? ((ng < STEP_S) ? ng : STEP_S) : 11'sd0;
        p1_x_d = bus.freeze ? p1_x_q : 10'(n1 + a1);
        p2_x_d = bus.freeze ? p2_x_q : 10'(n2 - a2);
        gap_d  = bus.freeze ? gap_q  : 10'(ng - a1 - a2);
        q1 = (bus.p1_state == ST_BASIC && gap_q <= BR) || (bus.p1_state == ST_DIR && gap_q <= DR);
        q2 = (bus.p2_state == ST_BASIC && gap_q <= BR) || (bus.p2_state == ST_DIR && gap_q <= DR);
        act1 = bus.p1_state == ST_BASIC || bus.p1_state == ST_DIR;
        act2 = bus.p2_state == ST_BASIC || bus.p2_state == ST_DIR;
        // A stunned defender still consumes the attack, so the latch sets regardless of the pulse.
        hit_p2_d = !bus.freeze && q1 && !lat1_q && !stun2;
        hit_p1_d = !bus.freeze && q2 && !lat2_q && !stun1;
        lat1_d = bus.freeze ? lat1_q : act1 && (lat1_q || q1);
        lat2_d = bus.freeze ? lat2_q : act2 && (lat2_q || q2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_x_q   <= 10'(P1_START);
            p2_x_q   <= 10'(P2_START);
            gap_q    <= 10'(P2_START - P1_START - BODY_W);
            hit_p1_q <= 1'b0;
            hit_p2_q <= 1'b0;
            lat1_q   <= 1'b0;
            lat2_q   <= 1'b0;
        end else begin
            p1_x_q   <= p1_x_d;
            p2_x_q   <= p2_x_d;
            gap_q    <= gap_d;
            hit_p1_q <= hit_p1_d;
            hit_p2_q <= hit_p2_d;
            lat1_q   <= lat1_d;
            lat2_q   <= lat2_d;
        end
    end

    assign bus.p1_x       = p1_x_q;
    assign bus.p2_x       = p2_x_q;
    assign bus.gap        = gap_q;
    assign bus.hitscan_p1 = hit_p1_q;
    assign bus.hitscan_p2 = hit_p2_q;
endmodule

// File: tb/tb_position_hit_unit.sv
// tb_position_hit_unit: directed movement, clamping and hitscan vectors with hand-computed expectations.
module tb_position_hit_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    position_hit_unit_if bus();
    position_hit_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input int n);
        bus.p1_state = a;
        bus.p2_state = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        bus.freeze = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.freeze = 1'b0;
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p1_x", bus.p1_x, 160);
        check("rst_p2_x", bus.p2_x, 448);
        check("rst_gap", bus.gap, 256);
        check("rst_hs1", bus.hitscan_p1, 0);
        check("rst_hs2", bus.hitscan_p2, 0);
        reset_n = 1'b1;
        drive(0, 0, 10);
        check("idle_p1_x", bus.p1_x, 160);
        check("idle_p2_x", bus.p2_x, 448);
        check("idle_gap", bus.gap, 256);
        check("idle_hs1", bus.hitscan_p1, 0);
        check("idle_hs2", bus.hitscan_p2, 0);

        drive(1, 0, 1);
        check("fwd1_p1_x", bus.p1_x, 163);
        check("fwd1_gap", bus.gap, 253);
        drive(1, 0, 99);
        check("fwd100_p1_x", bus.p1_x, 416);
        check("fwd100_gap", bus.gap, 0);
        check("fwd100_p2_x", bus.p2_x, 448);
        drive(1, 0, 5);
        check("fwd_hold_p1_x", bus.p1_x, 416);
        drive(1, 2, 1);
        check("chase_p1_x", bus.p1_x, 419);
        check("chase_p2_x", bus.p2_x, 451);
        check("chase_gap", bus.gap, 0);
        drive(0, 2, 60);
        check("wall_p2_x", bus.p2_x, 608);
        check("wall_gap", bus.gap, 157);

        do_reset();
        drive(1, 0, 72);
        check("g40_p1_x", bus.p1_x, 376);
        check("g40_gap", bus.gap, 40);
        drive(4, 0, 1);
        check("basic40_hs2", bus.hitscan_p2, 1);
        check("basic40_hs1", bus.hitscan_p1, 0);
        drive(4, 0, 1);
        check("basic40_once", bus.hitscan_p2, 0);
        drive(0, 0, 1);
        drive(4, 0, 1);
        check("rearm_hs2", bus.hitscan_p2, 1);
        drive(7, 0, 1);
        check("4to7_latched", bus.hitscan_p2, 0);
        drive(0, 0, 1);
        drive(1, 0, 10);
        check("g10_gap", bus.gap, 10);
        drive(4, 4, 1);
        check("trade_hs1", bus.hitscan_p1, 1);
        check("trade_hs2", bus.hitscan_p2, 1);
        drive(0, 0, 1);
        drive(4, 9, 1);
        check("stun_def_hs2", bus.hitscan_p2, 0);
        drive(4, 0, 1);
        check("stun_consumed", bus.hitscan_p2, 0);
        drive(0, 0, 1);
        drive(4, 0, 1);
        check("stun_rearm", bus.hitscan_p2, 1);
        drive(0, 0, 1);
        bus.freeze = 1'b1;
        drive(1, 2, 3);
        check("frz_p1_x", bus.p1_x, 406);
        check("frz_p2_x", bus.p2_x, 448);
        drive(4, 0, 2);
        check("frz_hs2", bus.hitscan_p2, 0);
        bus.freeze = 1'b0;
        drive(4, 0, 1);
        check("unfrz_hs2", bus.hitscan_p2, 1);
        drive(4, 0, 1);
        check("unfrz_once", bus.hitscan_p2, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_p1_x", bus.p1_x, 160);
        check("async_gap", bus.gap, 256);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(4, 1, 72);
        check("postrst_gap", bus.gap, 40);
        check("postrst_early", bus.hitscan_p2, 0);
        drive(4, 1, 1);
        check("postrst_hs2", bus.hitscan_p2, 1);
        check("postrst_gap2", bus.gap, 37);
        drive(0, 0, 1);

        do_reset();
        drive(2, 0, 60);
        check("wall_p1_x", bus.p1_x, 0);
        check("wall_p1_gap", bus.gap, 416);
        drive(1, 0, 120);
        check("g56_gap", bus.gap, 56);
        drive(7, 0, 1);
        check("dir56_hs2", bus.hitscan_p2, 1);
        drive(0, 0, 1);
        drive(4, 0, 1);
        check("basic56_hs2", bus.hitscan_p2, 0);
        drive(0, 7, 1);
        check("p2dir56_hs1", bus.hitscan_p1, 1);
        drive(0, 0, 1);
        drive(1, 0, 5);
        check("g41_p1_x", bus.p1_x, 375);
        check("g41_gap", bus.gap, 41);
        drive(4, 0, 1);
        check("basic41_hs2", bus.hitscan_p2, 0);
        drive(0, 0, 1);
        drive(7, 0, 1);
        check("dir41_hs2", bus.hitscan_p2, 1);
        drive(0, 0, 1);

        do_reset();
        drive(1, 0, 48);
        check("e_p1_x", bus.p1_x, 304);
        drive(0, 1, 40);
        check("e_p2_x", bus.p2_x, 336);
        check("e_gap0", bus.gap, 0);
        drive(2, 0, 110);
        check("e_p1_wall", bus.p1_x, 0);
        drive(1, 0, 100);
        check("e_p1_300", bus.p1_x, 300);
        check("e_gap4", bus.gap, 4);
        drive(1, 1, 1);
        check("split_p1_x", bus.p1_x, 302);
        check("split_p2_x", bus.p2_x, 334);
        check("split_gap", bus.gap, 0);
        drive(1, 1, 3);
        check("split_hold_p1", bus.p1_x, 302);
        check("split_hold_p2", bus.p2_x, 334);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
